// File: rtl/wb_master_cmd_arbiter_pkg.sv
// wb_master_cmd_arbiter_pkg: FSM state encoding and response constants shared by the arbiter files.
package wb_master_cmd_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_e;
   localparam logic [31:0] TIMEOUT_STATUS = 32'hFFFF_FFFF;
   localparam int          RESP_BIT       = 0;
endpackage

// File: rtl/wb_master_cmd_arbiter_rr_pick.sv
// wb_arb_rr_pick: combinational round-robin pick of the first valid requester at/after ptr_i.
module wb_arb_rr_pick #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [$clog2(NUM_REQ)-1:0] grant_o,
   output logic                       any_o
);
   localparam int IW = $clog2(NUM_REQ);
   int idx;
   always_comb begin
      grant_o = ptr_i;
      any_o   = 1'b0;
      idx     = 0;
      // scan farthest offset first so the nearest valid requester is written last
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr_i) + k) % NUM_REQ;
         if (req_i[IW'(idx)]) begin
            grant_o = IW'(idx);
            any_o   = 1'b1;
         end
      end
   end
endmodule

// File: rtl/wb_master_cmd_arbiter.sv
// wb_master_cmd_arbiter: round-robin share of one wishbone_master command port, one command in flight.
// Define WB_ARB_TIMEOUT_EN to synthesise an error response after TIMEOUT cycles in WAIT_RESP.
module wb_master_cmd_arbiter
   import wb_master_cmd_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [32*NUM_REQ-1:0]  req_command,
   input  logic [32*NUM_REQ-1:0]  req_address,
   input  logic [32*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]     req_ack,
   output logic [NUM_REQ-1:0]     resp_en,
   output logic [31:0]            resp_status,
   output logic [31:0]            resp_address,
   output logic [31:0]            resp_data,
   output logic                   mst_in_ready,
   output logic [31:0]            mst_in_command,
   output logic [31:0]            mst_in_address,
   output logic [31:0]            mst_in_data,
   output logic                   mst_out_ready,
   input  logic                   mst_out_en,
   input  logic [31:0]            mst_out_status,
   input  logic [31:0]            mst_out_address,
   input  logic [31:0]            mst_out_data,
   output logic                   stray_resp
);
   localparam int IW = $clog2(NUM_REQ);
   if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT < 2) begin : g_bad_cfg
      $error("wb_master_cmd_arbiter: NUM_REQ must be 2..4 and TIMEOUT >= 2");
   end
   state_e             state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d, owner_q, owner_d, grant;
   logic               any_valid;
   logic [31:0]        cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
   logic [31:0]        rstat_q, rstat_d, raddr_q, raddr_d, rdata_q, rdata_d;
   logic [NUM_REQ-1:0] resp_en_q, resp_en_d, owner_oh;
   logic               stray_q, stray_d, out_ready_q;
`ifdef WB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT);
   logic [TW-1:0] timer_q;
   always_ff @(posedge clk)
      timer_q <= (!rst || state_q != WAIT_RESP) ? '0 : timer_q + 1'b1;
`endif
   wb_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .any_o   (any_valid)
   );
   assign owner_oh       = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
   assign mst_in_ready   = state_q == ISSUE;
   assign req_ack        = mst_in_ready ? owner_oh : '0;
   assign mst_in_command = cmd_q;
   assign mst_in_address = addr_q;
   assign mst_in_data    = data_q;
   assign mst_out_ready  = out_ready_q;
   assign resp_en        = resp_en_q;
   assign resp_status    = rstat_q;
   assign resp_address   = raddr_q;
   assign resp_data      = rdata_q;
   assign stray_resp     = stray_q;
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      cmd_d     = cmd_q;
      addr_d    = addr_q;
      data_d    = data_q;
      rstat_d   = rstat_q;
      raddr_d   = raddr_q;
      rdata_d   = rdata_q;
      resp_en_d = '0;
      stray_d   = mst_out_en && state_q != WAIT_RESP;
      if (state_q == IDLE && any_valid) begin
         owner_d = grant;
         cmd_d   = req_command[{grant, 5'd0} +: 32];
         addr_d  = req_address[{grant, 5'd0} +: 32];
         data_d  = req_data[{grant, 5'd0} +: 32];
         state_d = ISSUE;
      end else if (state_q == ISSUE) begin
         ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
         state_d = cmd_q[RESP_BIT] ? WAIT_RESP : IDLE;
      end else if (state_q == WAIT_RESP) begin
         if (mst_out_en) begin
            resp_en_d = owner_oh;
            rstat_d   = mst_out_status;
            raddr_d   = mst_out_address;
            rdata_d   = mst_out_data;
            state_d   = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
         end else if (timer_q == TW'(TIMEOUT - 1)) begin
            resp_en_d = owner_oh;
            rstat_d   = TIMEOUT_STATUS;
            raddr_d   = addr_q;
            rdata_d   = '0;
            state_d   = IDLE;
`endif
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         cmd_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         rstat_q     <= '0;
         raddr_q     <= '0;
         rdata_q     <= '0;
         resp_en_q   <= '0;
         stray_q     <= 1'b0;
         out_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         rstat_q     <= rstat_d;
         raddr_q     <= raddr_d;
         rdata_q     <= rdata_d;
         resp_en_q   <= resp_en_d;
         stray_q     <= stray_d;
         out_ready_q <= state_d != ISSUE;
      end
   end
endmodule

// File: tb/tb_wb_master_cmd_arbiter.sv
// tb_wb_master_cmd_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_wb_master_cmd_arbiter;
   localparam int N   = 4;
   localparam int TMO = 8;
   logic clk = 1'b0, rst = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [32*N-1:0] req_command = '0, req_address = '0, req_data = '0;
   logic [N-1:0]    req_ack, resp_en;
   logic [31:0]     resp_status, resp_address, resp_data;
   logic            mst_in_ready, mst_out_ready, stray_resp;
   logic [31:0]     mst_in_command, mst_in_address, mst_in_data;
   logic            mst_out_en = 1'b0;
   logic [31:0]     mst_out_status = '0, mst_out_address = '0, mst_out_data = '0;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   wb_master_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_command(req_command), .req_address(req_address), .req_data(req_data),
      .req_ack(req_ack), .resp_en(resp_en),
      .resp_status(resp_status), .resp_address(resp_address), .resp_data(resp_data),
      .mst_in_ready(mst_in_ready), .mst_in_command(mst_in_command),
      .mst_in_address(mst_in_address), .mst_in_data(mst_in_data),
      .mst_out_ready(mst_out_ready), .mst_out_en(mst_out_en),
      .mst_out_status(mst_out_status), .mst_out_address(mst_out_address), .mst_out_data(mst_out_data),
      .stray_resp(stray_resp)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // round-robin rule: first valid requester at or after p, wrapping
   function automatic int pick(input logic [N-1:0] v, input int p);
      logic [N-1:0] r;
      for (int k = 0; k < N; k++) begin
         r = v >> ((p + k) % N);
         if (r[0]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [31:0] c, input logic [31:0] a, input logic [31:0] d);
      req_command[32*i +: 32] = c;
      req_address[32*i +: 32] = a;
      req_data[32*i +: 32]    = d;
   endtask

   task automatic do_reset();
      rst = 1'b0; req_valid = '0; mst_out_en = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(); tick();
      checks++;
      if ({req_ack, resp_en, resp_status, resp_address, resp_data, mst_in_ready, mst_in_command,
           mst_in_address, mst_in_data, mst_out_ready, stray_resp} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: ack=%b resp_en=%b in_ready=%b out_ready=%b stray=%b expected all 0",
                  req_ack, resp_en, mst_in_ready, mst_out_ready, stray_resp);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (mst_out_ready !== 1'b1) begin failures++; $display("FAIL idle_out_ready: got %b expected 1", mst_out_ready); end
   endtask

   task automatic test_single_response();
      set_req(0, 32'h1, 32'h10, 32'hAB);
      req_valid = 4'b0001;
      tick();
      checks++;
      if ({mst_in_ready, req_ack, mst_out_ready} !== {1'b1, 4'b0001, 1'b0}) begin
         failures++; $display("FAIL single_issue: ready=%b ack=%b out_ready=%b expected 1/0001/0", mst_in_ready, req_ack, mst_out_ready);
      end
      checks++;
      if ({mst_in_command, mst_in_address, mst_in_data} !== {32'h1, 32'h10, 32'hAB}) begin
         failures++; $display("FAIL single_payload: got %h/%h/%h expected 1/10/ab", mst_in_command, mst_in_address, mst_in_data);
      end
      req_valid = '0;
      tick();
      checks++;
      if ({mst_in_ready, req_ack, mst_out_ready, mst_in_command} !== {1'b0, 4'b0000, 1'b1, 32'h1}) begin
         failures++; $display("FAIL single_wait: ready=%b ack=%b out_ready=%b cmd=%h expected 0/0000/1/1", mst_in_ready, req_ack, mst_out_ready, mst_in_command);
      end
      mst_out_en = 1'b1; mst_out_status = 32'h1; mst_out_address = 32'h10; mst_out_data = 32'hAB;
      tick();
      mst_out_en = 1'b0;
      checks++;
      if ({resp_en, resp_status, resp_address, resp_data, stray_resp} !== {4'b0001, 32'h1, 32'h10, 32'hAB, 1'b0}) begin
         failures++; $display("FAIL single_resp: en=%b %h/%h/%h stray=%b expected 0001 1/10/ab 0", resp_en, resp_status, resp_address, resp_data, stray_resp);
      end
      tick();
      checks++;
      if ({resp_en, resp_status, req_ack} !== {4'b0000, 32'h1, 4'b0000}) begin
         failures++; $display("FAIL single_hold: en=%b status=%h ack=%b expected 0000/1/0000", resp_en, resp_status, req_ack);
      end
   endtask

   task automatic test_alternate();
      int p = 0, acks = 0, g;
      do_reset();
      set_req(0, 32'h100, 32'hA0, 32'hD0);
      set_req(1, 32'h200, 32'hA1, 32'hD1);
      req_valid = 4'b0011;
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if (mst_in_ready !== (c % 2 == 0)) begin failures++; $display("FAIL alt_ready c=%0d: got %b expected %b", c, mst_in_ready, c % 2 == 0); end
         if (mst_in_ready) begin
            g = pick(req_valid, p);
            acks++;
            checks++;
            if (req_ack !== 4'(1 << g) || mst_in_command !== req_command[32*g +: 32]) begin
               failures++; $display("FAIL alt_grant c=%0d: ack=%b cmd=%h expected ack bit %0d", c, req_ack, mst_in_command, g);
            end
            p = (g + 1) % N;
         end
         checks++;
         if ({resp_en, stray_resp} !== '0) begin failures++; $display("FAIL alt_quiet c=%0d: resp_en=%b stray=%b expected 0", c, resp_en, stray_resp); end
      end
      req_valid = '0;
      tick();
      checks++;
      if (acks != 4) begin failures++; $display("FAIL alt_count: got %0d grants expected 4", acks); end
   endtask

   task automatic test_wrap();
      do_reset();
      set_req(2, 32'h0, 32'h2, 32'h2);
      req_valid = 4'b0100;
      tick();
      checks++;
      if (req_ack !== 4'b0100) begin failures++; $display("FAIL wrap_prime: ack=%b expected 0100", req_ack); end
      set_req(1, 32'h10, 32'h1, 32'h1);
      set_req(3, 32'h30, 32'h3, 32'h3);
      req_valid = 4'b1010;
      tick();
      tick();
      checks++;
      if (req_ack !== 4'b1000 || mst_in_command !== 32'h30) begin failures++; $display("FAIL wrap_first: ack=%b cmd=%h expected 1000/30", req_ack, mst_in_command); end
      req_valid = 4'b0010;
      tick();
      tick();
      checks++;
      if (req_ack !== 4'b0010 || mst_in_command !== 32'h10) begin failures++; $display("FAIL wrap_second: ack=%b cmd=%h expected 0010/10", req_ack, mst_in_command); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_stray();
      mst_out_en = 1'b1;
      tick();
      mst_out_en = 1'b0;
      checks++;
      if ({stray_resp, resp_en} !== {1'b1, 4'b0000}) begin failures++; $display("FAIL stray_pulse: stray=%b resp_en=%b expected 1/0000", stray_resp, resp_en); end
      tick();
      checks++;
      if (stray_resp !== 1'b0) begin failures++; $display("FAIL stray_clear: got %b expected 0", stray_resp); end
   endtask

   task automatic test_timeout();
      set_req(1, 32'h11, 32'hCAFE0000, 32'h55);
      req_valid = 4'b0010;
      tick();
      checks++;
      if (req_ack !== 4'b0010) begin failures++; $display("FAIL tmo_issue: ack=%b expected 0010", req_ack); end
      req_valid = '0;
`ifdef WB_ARB_TIMEOUT_EN
      for (int t = 1; t <= TMO; t++) begin
         tick();
         checks++;
         if (resp_en !== '0) begin failures++; $display("FAIL tmo_early t=%0d: resp_en=%b expected 0000", t, resp_en); end
      end
      tick();
      checks++;
      if ({resp_en, resp_status, resp_address, resp_data} !== {4'b0010, 32'hFFFF_FFFF, 32'hCAFE0000, 32'h0}) begin
         failures++; $display("FAIL tmo_fire: en=%b %h/%h/%h expected 0010 ffffffff/cafe0000/0", resp_en, resp_status, resp_address, resp_data);
      end
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      for (int t = 1; t <= TMO; t++) tick();
      mst_out_en = 1'b1; mst_out_status = 32'h5; mst_out_address = 32'h6; mst_out_data = 32'h7;
      tick();
      mst_out_en = 1'b0;
      checks++;
      if ({resp_en, resp_status, resp_address, resp_data} !== {4'b0010, 32'h5, 32'h6, 32'h7}) begin
         failures++; $display("FAIL tmo_race: en=%b %h/%h/%h expected 0010 5/6/7", resp_en, resp_status, resp_address, resp_data);
      end
      tick();
      checks++;
      if (stray_resp !== 1'b0) begin failures++; $display("FAIL tmo_race_stray: got %b expected 0", stray_resp); end
`else
      for (int t = 1; t <= 5 * TMO; t++) begin
         tick();
         checks++;
         if ({resp_en, mst_in_ready} !== '0) begin failures++; $display("FAIL wait_forever t=%0d: resp_en=%b ready=%b expected 0", t, resp_en, mst_in_ready); end
      end
      mst_out_en = 1'b1; mst_out_status = 32'h5; mst_out_address = 32'h6; mst_out_data = 32'h7;
      tick();
      mst_out_en = 1'b0;
      checks++;
      if ({resp_en, resp_status, resp_address, resp_data} !== {4'b0010, 32'h5, 32'h6, 32'h7}) begin
         failures++; $display("FAIL late_resp: en=%b %h/%h/%h expected 0010 5/6/7", resp_en, resp_status, resp_address, resp_data);
      end
      tick();
`endif
   endtask

   task automatic test_reset_mid_wait();
      set_req(2, 32'h3, 32'h33, 32'h44);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({req_ack, resp_en, resp_status, resp_address, resp_data, mst_in_ready, mst_in_command,
           mst_in_address, mst_in_data, mst_out_ready, stray_resp} !== '0) begin
         failures++; $display("FAIL midrst_outputs: ack=%b resp_en=%b cmd=%h out_ready=%b expected all 0", req_ack, resp_en, mst_in_command, mst_out_ready);
      end
      rst = 1'b1;
      mst_out_en = 1'b1;
      tick();
      mst_out_en = 1'b0;
      checks++;
      if ({stray_resp, resp_en} !== {1'b1, 4'b0000}) begin failures++; $display("FAIL midrst_stray: stray=%b resp_en=%b expected 1/0000", stray_resp, resp_en); end
      for (int i = 0; i < N; i++) set_req(i, 32'(i) << 4, 32'h0, 32'h0);
      req_valid = 4'b1111;
      tick();
      checks++;
      if (req_ack !== 4'b0001) begin failures++; $display("FAIL midrst_ptr: ack=%b expected 0001", req_ack); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] pend = '0, prev_valid = '0;
      logic [31:0]  pc[N], pa[N], pd[N];
      logic [31:0]  rs = '0, ra = '0, rd = '0, last_cmd = '0;
      int p = 0, owner = 0, cnt = 0, g;
      bit free_prev = 1'b1, waiting = 1'b0, sent = 1'b0, sent_prev = 1'b0, issued_any = 1'b0;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         tick();
         checks++;
         if (mst_in_ready !== (free_prev && prev_valid != '0)) begin
            failures++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, mst_in_ready, free_prev && prev_valid != '0);
         end
         checks++;
         if (sent_prev) begin
            if ({resp_en, resp_status, resp_address, resp_data} !== {4'(1 << owner), rs, ra, rd}) begin
               failures++; $display("FAIL rnd_resp c=%0d: en=%b %h/%h/%h expected bit %0d %h/%h/%h", c, resp_en, resp_status, resp_address, resp_data, owner, rs, ra, rd);
            end
            waiting = 1'b0;
            sent = 1'b0;
         end else if (resp_en !== '0) begin
            failures++; $display("FAIL rnd_noresp c=%0d: resp_en=%b expected 0000", c, resp_en);
         end
         checks++;
         if (stray_resp !== 1'b0) begin failures++; $display("FAIL rnd_stray c=%0d: got %b expected 0", c, stray_resp); end
         g = pick(prev_valid, p);
         if (mst_in_ready && g >= 0) begin
            checks++;
            if ({req_ack, mst_in_command, mst_in_address, mst_in_data} !== {4'(1 << g), pc[g], pa[g], pd[g]}) begin
               failures++; $display("FAIL rnd_grant c=%0d: ack=%b cmd=%h expected bit %0d cmd %h", c, req_ack, mst_in_command, g, pc[g]);
            end
            p = (g + 1) % N;
            pend[g] = 1'b0;
            last_cmd = pc[g];
            issued_any = 1'b1;
            if (pc[g][0]) begin
               waiting = 1'b1;
               owner = g;
               cnt = $urandom_range(5, 1);
            end
         end else if (!mst_in_ready) begin
            checks++;
            if (req_ack !== '0 || (issued_any && mst_in_command !== last_cmd)) begin
               failures++; $display("FAIL rnd_idle c=%0d: ack=%b cmd=%h expected 0000 cmd %h", c, req_ack, mst_in_command, last_cmd);
            end
         end
         free_prev = !mst_in_ready && !waiting;
         mst_out_en = 1'b0;
         sent_prev = 1'b0;
         if (waiting && !sent) begin
            if (cnt == 0) begin
               rs = $urandom; ra = $urandom; rd = $urandom;
               mst_out_status = rs; mst_out_address = ra; mst_out_data = rd;
               mst_out_en = 1'b1;
               sent = 1'b1;
               sent_prev = 1'b1;
            end else cnt--;
         end
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && c < 560 && $urandom_range(2, 0) == 0) begin
               pc[i] = $urandom; pa[i] = $urandom; pd[i] = $urandom;
               set_req(i, pc[i], pa[i], pd[i]);
               pend[i] = 1'b1;
            end
         end
         req_valid = pend;
         prev_valid = pend;
      end
      checks++;
      if (pend != '0 || waiting) begin failures++; $display("FAIL rnd_drain: pending=%b waiting=%b expected 0000/0", pend, waiting); end
   endtask

   initial begin
      test_reset();
      test_single_response();
      test_alternate();
      test_wrap();
      test_stray();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
